// File: rtl/brew_sequencer.sv
// ============================================================================
// Module  : brew_sequencer
// Brief   : Coin-credit drink sequencer IDLE->GRIND->HEAT->POUR->DONE with a
//           tick prescaler. Optional cancel/refund port under BREW_CANCEL_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module brew_sequencer #(
    parameter int TICK_DIV = 50000,
    parameter int PRICE0   = 3,
    parameter int PRICE1   = 4,
    parameter int PRICE2   = 6,
    parameter int GRIND_T  = 4,
    parameter int HEAT_T   = 6,
    parameter int POUR_T   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin,
    input  logic [1:0] sel,
    input  logic       start,
`ifdef BREW_CANCEL_EN
    input  logic       cancel,
`endif
    output logic [2:0] phase,
    output logic       step_en,
    output logic       busy,
    output logic [3:0] credit,
    output logic [3:0] change,
    output logic       change_vld,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRIND = 3'd1,
        S_HEAT  = 3'd2,
        S_POUR  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int              PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

    state_t      state, state_nx;
    logic [PW-1:0] presc;
    logic [15:0] tcnt;
    logic [15:0] dur;
    logic [1:0]  sel_q;
    logic [3:0]  price;
    logic        tick_last, phase_end;
    logic        cancel_ok, start_ok, start_bad, refund;
    logic [3:0]  credit_base, credit_nx, change_nx;
    logic        err_nx;

    assign phase     = state;
    assign tick_last = (presc == PRESC_LAST);

    always_comb begin
        dur = 16'd1;
        case (state)
            S_GRIND: dur = 16'(GRIND_T);
            S_HEAT:  dur = 16'(HEAT_T);
            S_POUR: begin
                case (sel_q)
                    2'd0:    dur = 16'(POUR_T);
                    2'd1:    dur = 16'(POUR_T * 2);
                    default: dur = 16'(POUR_T * 3);
                endcase
            end
            default: dur = 16'd1;
        endcase
    end

    assign phase_end = tick_last && (tcnt == dur - 16'd1);

    always_comb begin
        price = 4'hF;
        case (sel)
            2'd0:    price = 4'(PRICE0);
            2'd1:    price = 4'(PRICE1);
            2'd2:    price = 4'(PRICE2);
            default: price = 4'hF;
        endcase
    end

`ifdef BREW_CANCEL_EN
    assign cancel_ok = cancel && (state == S_IDLE) && (credit != 4'd0);
`else
    assign cancel_ok = 1'b0;
`endif

    // A valid cancel pre-empts start; start decisions use the pre-coin credit.
    assign start_ok  = (state == S_IDLE) && start && !cancel_ok &&
                       (sel != 2'd3) && (credit >= price);
    assign start_bad = (state == S_IDLE) && start && !cancel_ok &&
                       ((sel == 2'd3) || (credit < price));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start_ok)  state_nx = S_GRIND;
            S_GRIND: if (phase_end) state_nx = S_HEAT;
            S_HEAT:  if (phase_end) state_nx = S_POUR;
            S_POUR:  if (phase_end) state_nx = S_DONE;
            S_DONE:  if (phase_end) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign refund = ((state == S_POUR) && phase_end) || cancel_ok;

    always_comb begin
        credit_base = credit;
        change_nx   = change;
        err_nx      = start_bad;
        if (refund) begin
            change_nx   = credit;
            credit_base = 4'd0;
        end else if (start_ok) begin
            credit_base = credit - price;
        end
        credit_nx = credit_base;
        if (coin) begin
            if (credit_base == 4'hF) err_nx    = 1'b1;
            else                     credit_nx = credit_base + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            presc      <= '0;
            tcnt       <= '0;
            sel_q      <= 2'd0;
            credit     <= 4'd0;
            change     <= 4'd0;
            change_vld <= 1'b0;
            step_en    <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nx;
            credit     <= credit_nx;
            change     <= change_nx;
            change_vld <= refund;
            step_en    <= (state_nx != state);
            busy       <= (state_nx != S_IDLE);
            err        <= err_nx;
            if (start_ok) sel_q <= sel;
            // Prescaler and tick counter restart on every phase entry.
            if ((state_nx != state) || (state == S_IDLE)) begin
                presc <= '0;
                tcnt  <= '0;
            end else if (tick_last) begin
                presc <= '0;
                tcnt  <= tcnt + 16'd1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_brew_sequencer.sv
// ============================================================================
// Module  : tb_brew_sequencer
// Brief   : Directed self-checking bench for brew_sequencer at TICK_DIV=4.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_brew_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       start = 1'b0;
    logic       cancel = 1'b0;
    logic [2:0] phase;
    logic       step_en, busy, change_vld, err;
    logic [3:0] credit, change;

    int checks = 0;
    int errors = 0;
    int pc[5];
    int n_step, n_cv, last_chg, cv_phase;

    brew_sequencer #(.TICK_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coin       (coin),
        .sel        (sel),
        .start      (start),
`ifdef BREW_CANCEL_EN
        .cancel     (cancel),
`endif
        .phase      (phase),
        .step_en    (step_en),
        .busy       (busy),
        .credit     (credit),
        .change     (change),
        .change_vld (change_vld),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coins(input int n);
        for (int i = 0; i < n; i++) begin
            coin = 1'b1;
            tick();
            coin = 1'b0;
        end
    endtask

    task automatic do_start(input logic [1:0] s);
        sel   = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Samples from the current cycle until IDLE, tallying per-phase cycles.
    task automatic run_brew();
        bit done = 1'b0;
        for (int k = 0; k < 5; k++) pc[k] = 0;
        n_step = 0; n_cv = 0; last_chg = -1; cv_phase = -1;
        for (int i = 0; i < 400; i++) begin
            if (phase <= 3'd4) pc[phase]++;
            n_step += int'(step_en);
            if (change_vld) begin
                n_cv++;
                last_chg = int'(change);
                cv_phase = int'(phase);
            end
            if (phase == 3'd0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk("brew_finished", int'(done), 1);
    endtask

    initial begin
        #3;
        chk("rst_phase",  phase, 0);
        chk("rst_credit", credit, 0);
        chk("rst_busy",   busy, 0);
        chk("rst_step",   step_en, 0);
        chk("rst_err",    err, 0);
        chk("rst_cvld",   change_vld, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 4 coins, drink 1
        put_coins(4);
        chk("c4_credit", credit, 4);
        do_start(2'd1);
        chk("s1_phase",  phase, 1);
        chk("s1_credit", credit, 0);
        chk("s1_step",   step_en, 1);
        chk("s1_busy",   busy, 1);
        tick();
        chk("s1_step_off", step_en, 0);
        run_brew();
        chk("s1_steps", n_step, 4);

        // Insufficient credit
        put_coins(2);
        do_start(2'd0);
        chk("poor_err",    err, 1);
        chk("poor_phase",  phase, 0);
        chk("poor_credit", credit, 2);
        tick();
        chk("poor_err_off", err, 0);

        // Full brew of drink 2 from 7 credits
        put_coins(5);
        chk("c7_credit", credit, 7);
        do_start(2'd2);
        chk("d2_credit", credit, 1);
        run_brew();
        chk("d2_grind",  pc[1], 16);
        chk("d2_heat",   pc[2], 24);
        chk("d2_pour",   pc[3], 36);
        chk("d2_done",   pc[4], 4);
        chk("d2_steps",  n_step, 5);
        chk("d2_ncv",    n_cv, 1);
        chk("d2_change", last_chg, 1);
        chk("d2_cvph",   cv_phase, 4);
        chk("d2_credit_end", credit, 0);
        chk("d2_busy_end",   busy, 0);

        // Saturation
        put_coins(15);
        chk("sat15_credit", credit, 15);
        chk("sat15_err",    err, 0);
        put_coins(1);
        chk("sat16_credit", credit, 15);
        chk("sat16_err",    err, 1);

        // Reset during HEAT
        do_start(2'd0);
        chk("r_credit", credit, 12);
        for (int i = 0; i < 100 && phase != 3'd2; i++) tick();
        chk("r_in_heat", phase, 2);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("r_phase",  phase, 0);
        chk("r_credit0", credit, 0);
        chk("r_busy",   busy, 0);
        chk("r_cvld",   change_vld, 0);
        tick();
        chk("r_cvld_hold", change_vld, 0);
        rst_n = 1'b1;
        tick();
        chk("r_after_credit", credit, 0);

        // Coin coincident with accepted start, then start while busy
        put_coins(3);
        coin = 1'b1;
        do_start(2'd0);
        coin = 1'b0;
        chk("cs_phase",  phase, 1);
        chk("cs_credit", credit, 1);
        put_coins(3);
        do_start(2'd0);
        chk("busy_start_err",   err, 0);
        chk("busy_start_phase", phase, 1);
        chk("busy_start_credit", credit, 4);
        run_brew();
        chk("cs_change", last_chg, 4);
        chk("cs_credit_end", credit, 0);

        // Invalid select
        put_coins(6);
        do_start(2'd3);
        chk("sel3_err",    err, 1);
        chk("sel3_phase",  phase, 0);
        chk("sel3_credit", credit, 6);

`ifdef BREW_CANCEL_EN
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cx6_cvld",   change_vld, 1);
        chk("cx6_change", change, 6);
        put_coins(5);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cx5_cvld",   change_vld, 1);
        chk("cx5_change", change, 5);
        chk("cx5_credit", credit, 0);
        put_coins(4);
        do_start(2'd1);
        put_coins(1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cxg_cvld",   change_vld, 0);
        chk("cxg_credit", credit, 1);
        chk("cxg_phase",  phase, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/brew_sequencer.md
BREW_SEQUENCER -- requirements
Module: brew_sequencer

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000, meaning clk cycles per timing tick (>=2).
REQ-002 The block SHALL have parameter PRICE0 / PRICE1 / PRICE2, defaults 3 / 4 / 6, meaning credit units for drinks 0/1/2.
REQ-003 The block SHALL have parameter GRIND_T / HEAT_T / POUR_T, defaults 4 / 6 / 3, meaning phase durations in ticks (>=1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port coin, input, 1 bit: one-cycle pulse adding one credit unit.
REQ-007 The block SHALL have port sel, input, 2 bits: drink select; 0/1/2 valid, 3 invalid; sampled only with start.
REQ-008 The block SHALL have port start, input, 1 bit: one-cycle brew request.
REQ-009 The block SHALL have port phase, output, 3 bits: 0 IDLE, 1 GRIND, 2 HEAT, 3 POUR, 4 DONE.
REQ-010 The block SHALL have port step_en, output, 1 bit: one-cycle pulse on every phase transition; drives the downstream 5-step phase counter enable.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever phase != IDLE.
REQ-012 The block SHALL have port credit, output, 4 bits: current credit, registered.
REQ-013 The block SHALL have port change / change_vld, outputs, 4 bits / 1 bit: refund amount, valid for one cycle.
REQ-014 The block SHALL have port err, output, 1 bit: one-cycle pulse on a rejected request or credit overflow.

Function
REQ-015 The FSM SHALL step IDLE->GRIND->HEAT->POUR->DONE->IDLE only; no other transitions exist, and any illegal encoding SHALL go to IDLE.
REQ-016 In IDLE, start with sel<=2 and credit>=PRICE[sel] SHALL, on the next edge: enter GRIND, subtract the price from credit, and pulse step_en.
REQ-017 In IDLE, start with sel==3 or credit<PRICE[sel] SHALL pulse err on the next cycle, with no state or credit change.
REQ-018 Start while busy SHALL be ignored, with no err.
REQ-019 Phase durations SHALL be exact: GRIND GRIND_T*TICK_DIV cycles, HEAT HEAT_T*TICK_DIV cycles, POUR POUR_T*(sel_latched+1)*TICK_DIV cycles, DONE 1*TICK_DIV cycles.
REQ-020 The tick prescaler and the phase tick counter SHALL both restart on every phase entry.
REQ-021 sel SHALL be latched at the accepted start and held until IDLE.
REQ-022 Entering DONE SHALL pulse change_vld with change=credit (auto-refund of the remainder) and clear credit in the same edge.
REQ-023 step_en SHALL pulse exactly 5 times per brew, once on each transition; step_en and phase change on the same edge.
REQ-024 coin SHALL be accepted in every phase; at credit==15, coin SHALL leave credit at 15 and pulse err (saturation).
REQ-025 Coin and accepted start in the same cycle SHALL give credit_next = credit - price + 1, with the start decision using the pre-coin credit.
REQ-026 Coin on the DONE-entry edge SHALL give change = old credit and credit_next = 1.
REQ-027 All outputs SHALL be registered, with no combinational input-to-output paths.

Reset
REQ-028 rst_n low SHALL immediately force: phase=0, credit=0, change=0, change_vld=0, step_en=0, err=0, busy=0, prescaler and counters=0.
REQ-029 Reset mid-brew SHALL abort with no refund and no step_en pulse; the credit is lost.
REQ-030 After rst_n deasserts, the first accepted action SHALL occur no earlier than the first rising edge.

Configuration
REQ-031 With BREW_CANCEL_EN defined, the block SHALL add input port cancel (1 bit, one-cycle pulse).
REQ-032 Cancel in IDLE with credit>0 SHALL pulse change_vld with change=credit and clear credit; cancel with credit==0 or while busy SHALL be ignored.
REQ-033 Cancel and start in the same IDLE cycle: cancel SHALL win and start SHALL be ignored with no err.
REQ-034 Without BREW_CANCEL_EN, the cancel port and its logic SHALL be absent, and credit SHALL persist in IDLE until a purchase.

Verification (TICK_DIV=4, defaults otherwise)
REQ-035 The bench SHALL apply 4 coins, then start sel=1 -> GRIND entered next edge, credit 0, step_en 1 cycle, busy 1.
REQ-036 The bench SHALL apply 2 coins, then start sel=0 -> err pulse, phase stays 0, credit stays 2.
REQ-037 The bench SHALL apply 7 coins, then start sel=2 -> phase durations 16/24/36/4 cycles, DONE entry gives change=1 with change_vld, 5 step_en pulses, credit 0.
REQ-038 The bench SHALL apply 16 coins -> credit 15, err on the 16th coin.
REQ-039 The bench SHALL assert rst_n low during HEAT -> phase 0 and credit 0 asynchronously, with no change_vld.
REQ-040 With BREW_CANCEL_EN, the bench SHALL apply 5 coins then cancel -> change=5 with change_vld, credit 0; cancel during GRIND ignored.
